// File: rtl/seg_capture_pkg.sv
// Shared seven-segment definitions: glyph table, blank pattern, capture FSM states.
package seg_capture_pkg;

    // Canonical glyphs, bit6=g .. bit0=a, indexed by hex value.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // All segments dark; never a legal glyph.
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_e;

endpackage

// File: rtl/seg_glyph_encode.sv
// Combinational segment pattern -> {illegal, nibble}, driven from the shared glyph table.
module seg_glyph_encode
    import seg_capture_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       illegal_o,
    output logic [3:0] nib_o
);

    // Table search; anything not in the table (including blank) is illegal with nibble 0.
    always_comb begin
        illegal_o = 1'b1;
        nib_o     = '0;
        if (seg_i != SEG_BLANK) begin
            for (int unsigned i = 0; i < 16; i++) begin
                if (seg_i == GLYPH_TABLE[i]) begin
                    illegal_o = 1'b0;
                    nib_o     = 4'(i);
                end
            end
        end
    end

endmodule

// File: rtl/seg_capture.sv
// Sniffs a multiplexed seven-segment bus, recovers per-digit hex nibbles after a stable
// dwell, and publishes a coherent snapshot once every digit has been captured.
module seg_capture
    import seg_capture_pkg::*;
#(
    parameter int unsigned COM_ANODE      = 1,
    parameter int unsigned DIG_ACTIVE_LOW = 1,
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned STABLE_CYCLES  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_in,
    output logic [4*NUM_DIGITS-1:0] digit_nib,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    digit_update,
    output logic [4*NUM_DIGITS-1:0] frame_value,
    output logic                    frame_err,
    output logic                    frame_valid
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned SW = 7 + NUM_DIGITS;

    logic [6:0]              seg_s1_q, seg_s2_q;
    logic [NUM_DIGITS-1:0]   dig_s1_q, dig_s2_q;

    logic [6:0]              seg_n;
    logic [NUM_DIGITS-1:0]   dig_n;
    logic [SW-1:0]           smp;
    logic                    smp_onehot;

    state_e                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [SW-1:0]           lat_q;
    logic [NUM_DIGITS-1:0]   seen_q;
    logic [4*NUM_DIGITS-1:0] nib_q, fval_q;
    logic [NUM_DIGITS-1:0]   err_q;
    logic                    upd_q, ferr_q, fvalid_q;

    logic                    enc_illegal;
    logic [3:0]              enc_nib;
    logic [4*NUM_DIGITS-1:0] nib_d;
    logic [NUM_DIGITS-1:0]   err_d, seen_d;

    // Two-flop synchronizer for the asynchronous bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1_q <= '0;
            seg_s2_q <= '0;
            dig_s1_q <= '0;
            dig_s2_q <= '0;
        end else begin
            seg_s1_q <= seg_in;
            seg_s2_q <= seg_s1_q;
            dig_s1_q <= dig_in;
            dig_s2_q <= dig_s1_q;
        end
    end

    assign seg_n      = (COM_ANODE != 0)      ? ~seg_s2_q : seg_s2_q;
    assign dig_n      = (DIG_ACTIVE_LOW != 0) ? ~dig_s2_q : dig_s2_q;
    assign smp        = {seg_n, dig_n};
    assign smp_onehot = $onehot(dig_n);

    seg_glyph_encode u_enc (
        .seg_i     (seg_n),
        .illegal_o (enc_illegal),
        .nib_o     (enc_nib)
    );

    // Digit state as it would look after a capture of the currently strobed digit.
    always_comb begin
        nib_d  = nib_q;
        err_d  = err_q;
        seen_d = seen_q;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (dig_n[i]) begin
                nib_d[4*i +: 4] = enc_nib;
                err_d[i]        = enc_illegal;
                seen_d[i]       = 1'b1;
            end
        end
    end

    // Dwell FSM with registered capture and frame snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            lat_q    <= '0;
            seen_q   <= '0;
            nib_q    <= '0;
            err_q    <= '0;
            upd_q    <= 1'b0;
            fval_q   <= '0;
            ferr_q   <= 1'b0;
            fvalid_q <= 1'b0;
        end else begin
            upd_q    <= 1'b0;
            fvalid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (smp_onehot) begin
                        state_q <= ST_SETTLE;
                        cnt_q   <= CW'(1);
                        lat_q   <= smp;
                    end
                end
                ST_SETTLE: begin
                    if (smp == lat_q) begin
                        // This edge sees the final sample of the dwell, so capture now.
                        if (cnt_q >= CW'(STABLE_CYCLES - 1)) begin
                            state_q <= ST_HELD;
                            cnt_q   <= CW'(STABLE_CYCLES);
                            nib_q   <= nib_d;
                            err_q   <= err_d;
                            upd_q   <= 1'b1;
                            if (&seen_d) begin
                                fval_q   <= nib_d;
                                ferr_q   <= |err_d;
                                fvalid_q <= 1'b1;
                                seen_q   <= '0;
                            end else begin
                                seen_q   <= seen_d;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end else if (smp_onehot) begin
                        cnt_q <= CW'(1);
                        lat_q <= smp;
                    end else begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                end
                ST_HELD: begin
                    if (smp != lat_q) begin
                        if (smp_onehot) begin
                            state_q <= ST_SETTLE;
                            cnt_q   <= CW'(1);
                            lat_q   <= smp;
                        end else begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign digit_nib    = nib_q;
    assign digit_err    = err_q;
    assign digit_update = upd_q;
    assign frame_value  = fval_q;
    assign frame_err    = ferr_q;
    assign frame_valid  = fvalid_q;

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture with a run-length reference model checked every cycle.
module tb_seg_capture;

    localparam int STABLE = 4;

    logic        clk;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  dig_in;
    logic [15:0] digit_nib;
    logic [3:0]  digit_err;
    logic        digit_update;
    logic [15:0] frame_value;
    logic        frame_err;
    logic        frame_valid;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int upd_cnt = 0;
    int fv_cnt = 0;
    int last_upd = -1;
    int t0;

    seg_capture #(
        .COM_ANODE      (1),
        .DIG_ACTIVE_LOW (1),
        .NUM_DIGITS     (4),
        .STABLE_CYCLES  (STABLE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .seg_in       (seg_in),
        .dig_in       (dig_in),
        .digit_nib    (digit_nib),
        .digit_err    (digit_err),
        .digit_update (digit_update),
        .frame_value  (frame_value),
        .frame_err    (frame_err),
        .frame_valid  (frame_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    bit [6:0]  glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [6:0]  m_seg1 = '0, m_seg2 = '0;
    logic [3:0]  m_dig1 = '0, m_dig2 = '0;
    logic [10:0] run_val = '0;
    int          run_len = 0;
    logic [15:0] e_nib = '0, e_fval = '0;
    logic [3:0]  e_err = '0, seen = '0;
    logic        e_upd = 0, e_fv = 0, e_ferr = 0;

    initial begin
        logic [6:0] s;
        logic [3:0] d;
        int di, gv;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_seg1 = '0; m_seg2 = '0; m_dig1 = '0; m_dig2 = '0;
                run_len = 0; run_val = '0;
                e_nib = '0; e_err = '0; seen = '0; e_fval = '0;
                e_upd = 0; e_fv = 0; e_ferr = 0;
            end else begin
                s = ~m_seg2;
                d = ~m_dig2;
                m_seg2 = m_seg1; m_dig2 = m_dig1;
                m_seg1 = seg_in; m_dig1 = dig_in;
                e_upd = 0;
                e_fv = 0;
                if ($countones(d) != 1) begin
                    run_len = 0;
                end else if (run_len != 0 && {s, d} == run_val) begin
                    if (run_len < STABLE) begin
                        run_len++;
                        if (run_len == STABLE) begin
                            di = 0;
                            for (int k = 0; k < 4; k++) if (d[k]) di = k;
                            gv = -1;
                            for (int k = 0; k < 16; k++) if (s == glyph[k]) gv = k;
                            e_nib[4*di +: 4] = (gv < 0) ? 4'h0 : 4'(gv);
                            e_err[di] = (gv < 0);
                            seen[di] = 1'b1;
                            e_upd = 1;
                            if (seen == 4'hF) begin
                                e_fval = e_nib;
                                e_ferr = |e_err;
                                e_fv = 1;
                                seen = '0;
                            end
                        end
                    end
                end else begin
                    run_val = {s, d};
                    run_len = 1;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle model comparison and pulse bookkeeping.
    initial forever begin
        @(negedge clk);
        tests++;
        if ({digit_nib, digit_err, digit_update, frame_value, frame_err, frame_valid} !==
            {e_nib, e_err, e_upd, e_fval, e_ferr, e_fv}) begin
            fails++;
            $display("FAIL model_cmp cyc=%0d got nib=%h err=%b upd=%b fval=%h ferr=%b fv=%b required nib=%h err=%b upd=%b fval=%h ferr=%b fv=%b",
                     cyc, digit_nib, digit_err, digit_update, frame_value, frame_err, frame_valid,
                     e_nib, e_err, e_upd, e_fval, e_ferr, e_fv);
        end
        if (digit_update === 1'b1) begin
            upd_cnt++;
            last_upd = cyc;
        end
        if (frame_valid === 1'b1) fv_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [6:0] seg_hi, input logic [3:0] dig_raw, input int n);
        seg_in = ~seg_hi;
        dig_in = dig_raw;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        hold(7'h00, 4'hF, n);
    endtask

    task automatic clr();
        #1;
        upd_cnt = 0;
        fv_cnt = 0;
    endtask

    initial begin
        rst = 1'b1;
        seg_in = 7'h7F;
        dig_in = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        check("reset_nib", 32'(digit_nib), 32'h0);
        check("reset_flags", {26'd0, digit_err, digit_update, frame_valid}, 32'h0);
        #1 rst = 1'b0;
        @(negedge clk);

        // 1. capture something, then reset in the middle of a new dwell
        clr();
        hold(7'h79, 4'b1011, 8);
        idle(2);
        #1;
        check("t1_digit2_E", 32'(digit_nib[11:8]), 32'hE);
        hold(7'h4F, 4'b1110, 4);
        #2 rst = 1'b1;
        #1;
        check("t1_rst_nib", 32'(digit_nib), 32'h0);
        check("t1_rst_upd", 32'(digit_update), 32'h0);
        seg_in = 7'h7F;
        dig_in = 4'hF;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        clr();
        @(negedge clk);
        idle(10);
        #1;
        check("t1_no_upd_after_rst", 32'(upd_cnt), 32'd0);

        // 2. single digit latency
        clr();
        t0 = cyc;
        hold(7'h5B, 4'b1110, 10);
        idle(2);
        #1;
        check("t2_upd_count", 32'(upd_cnt), 32'd1);
        check("t2_latency", 32'(last_upd - t0), 32'd6);
        check("t2_nib0", 32'(digit_nib[3:0]), 32'h2);
        check("t2_err0", 32'(digit_err[0]), 32'h0);

        // 3. full frame 1,2,3,4
        clr();
        for (int d = 0; d < 4; d++) hold(glyph[d + 1], ~(4'b0001 << d), 8);
        idle(8);
        #1;
        check("t3_upd_count", 32'(upd_cnt), 32'd4);
        check("t3_fv_count", 32'(fv_cnt), 32'd1);
        check("t3_frame_value", 32'(frame_value), 32'h4321);
        check("t3_frame_err", 32'(frame_err), 32'h0);

        // 4. glitching digit 1, then a clean dwell
        clr();
        for (int i = 0; i < 6; i++) hold((i % 2) ? 7'h7D : 7'h6D, 4'b1101, 3);
        #1;
        check("t4_glitch_no_upd", 32'(upd_cnt), 32'd0);
        hold(7'h07, 4'b1101, 5);
        idle(8);
        #1;
        check("t4_hold_one_upd", 32'(upd_cnt), 32'd1);
        check("t4_nib1", 32'(digit_nib[7:4]), 32'h7);

        // 5. ghosting: two strobes at once
        clr();
        hold(7'h7F, 4'b1100, 20);
        idle(4);
        #1;
        check("t5_ghost_no_upd", 32'(upd_cnt), 32'd0);

        // 6. blank glyph on digit 3, frame with error, then legal F
        clr();
        hold(7'h00, 4'b0111, 8);
        idle(4);
        #1;
        check("t6_err3", 32'(digit_err[3]), 32'h1);
        check("t6_nib3", 32'(digit_nib[15:12]), 32'h0);
        check("t6_upd", 32'(upd_cnt), 32'd1);
        clr();
        hold(7'h67, 4'b1110, 8);
        hold(7'h77, 4'b1011, 8);
        idle(8);
        #1;
        check("t6_fv_count", 32'(fv_cnt), 32'd1);
        check("t6_frame_err", 32'(frame_err), 32'h1);
        check("t6_frame_value", 32'(frame_value), 32'h0A79);
        hold(7'h71, 4'b0111, 8);
        idle(4);
        #1;
        check("t6_err3_clear", 32'(digit_err), 32'h0);
        check("t6_nib3_F", 32'(digit_nib[15:12]), 32'hF);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
